// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin front end issuing one request at a time to the shared memory
// and returning read data, a write acknowledge or a timeout error to the granted processor.
module mem_req_arbiter #(
    parameter int NUM_PROCESSORS = 4,
    parameter int ADDR_W         = 14,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_PROCESSORS-1:0]        proc_req,
    input  logic [NUM_PROCESSORS-1:0]        proc_we,
    input  logic [NUM_PROCESSORS*ADDR_W-1:0] proc_addr,
    input  logic [NUM_PROCESSORS*DATA_W-1:0] proc_wdata,
    output logic [NUM_PROCESSORS-1:0]        proc_done,
    output logic                             proc_err,
    output logic [DATA_W-1:0]                proc_rdata,
    output logic                             processor_req_0,
    output logic                             processor_req_1,
    output logic                             processor_req_2,
    output logic                             processor_req_3,
    output logic                             mem_read_req,
    output logic                             mem_write_req,
    output logic [ADDR_W-1:0]                addr,
    output logic [DATA_W-1:0]                mem_write_data,
    input  logic [DATA_W-1:0]                mem_read_data,
    input  logic                             processor_resp_0,
    input  logic                             processor_resp_1,
    input  logic                             processor_resp_2,
    input  logic                             processor_resp_3
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_t                      state_q, state_d;
    logic [1:0]                  rr_q, rr_d, gnt_idx, idx;
    logic [7:0]                  wait_cnt_q, wait_cnt_d;
    logic [NUM_PROCESSORS-1:0]   req_q, req_d, done_q, done_d;
    logic                        err_q, err_d, rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [DATA_W-1:0]           wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_PROCESSORS-1:0]   resp;
    logic                        found, resp_ok;

    assign resp    = {processor_resp_3, processor_resp_2, processor_resp_1, processor_resp_0};
    // response bits are sticky, so the first WAIT cycle cannot trust them
    assign resp_ok = (wait_cnt_q != 8'd0) && |(resp & req_q);

    always_comb begin
        found   = 1'b0;
        gnt_idx = 2'd0;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_q + 2'(i);
            if (!found && proc_req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        wait_cnt_d = wait_cnt_q;
        req_d      = req_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        done_d     = '0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                req_d      = '0;
                rd_d       = 1'b0;
                wr_d       = 1'b0;
                addr_d     = '0;
                wdata_d    = '0;
                wait_cnt_d = 8'd0;
                if (found) begin
                    req_d[gnt_idx] = 1'b1;
                    wr_d           = proc_we[gnt_idx];
                    rd_d           = ~proc_we[gnt_idx];
                    addr_d         = proc_addr[gnt_idx*ADDR_W +: ADDR_W];
                    wdata_d        = proc_wdata[gnt_idx*DATA_W +: DATA_W];
                    rr_d           = gnt_idx + 2'd1;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (resp_ok || wait_cnt_q >= TMO) begin
                    state_d = DONE;
                    req_d   = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = req_q;
                    err_d   = ~resp_ok;
                    rdata_d = (resp_ok && rd_q) ? mem_read_data : '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_q       <= 2'd0;
            wait_cnt_q <= 8'd0;
            req_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            wait_cnt_q <= wait_cnt_d;
            req_q      <= req_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign proc_done       = done_q;
    assign proc_err        = err_q;
    assign proc_rdata      = rdata_q;
    assign processor_req_0 = req_q[0];
    assign processor_req_1 = req_q[1];
    assign processor_req_2 = req_q[2];
    assign processor_req_3 = req_q[3];
    assign mem_read_req    = rd_q;
    assign mem_write_req   = wr_q;
    assign addr            = addr_q;
    assign mem_write_data  = wdata_q;
endmodule
